// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg: shared widths and opcode set of the 3-stage adder processor
package operand_fetch_stage_pkg;
    localparam int DATA_W  = 8;
    localparam int REG_CNT = 8;
    localparam int ADDR_W  = $clog2(REG_CNT);
    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        ADC = 2'd2,
        INC = 2'd3
    } op_t;
endpackage

// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: instruction, operand and writeback channels of the operand fetch stage
interface operand_fetch_stage_if
    import operand_fetch_stage_pkg::op_t;
#(
    parameter int DATA_W = operand_fetch_stage_pkg::DATA_W,
    parameter int ADDR_W = operand_fetch_stage_pkg::ADDR_W
);
    logic              in_valid;
    logic              in_ready;
    op_t               in_op;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic              in_use_imm;
    logic [DATA_W-1:0] in_imm;
    logic [ADDR_W-1:0] in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              out_ci;
    logic [ADDR_W-1:0] out_rd;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_carry_en;
    logic              wb_carry;

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_use_imm, in_imm, in_rd,
        input  out_ready, wb_en, wb_addr, wb_data, wb_carry_en, wb_carry,
        output in_ready, out_valid, out_a, out_b, out_ci, out_rd
    );

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_use_imm, in_imm, in_rd,
        output out_ready, wb_en, wb_addr, wb_data, wb_carry_en, wb_carry,
        input  in_ready, out_valid, out_a, out_b, out_ci, out_rd
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: two async read ports with write bypass, one sync write port, r0 hardwired to zero
module reg_file_2r1w #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 8,
    localparam int ADDR_W = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] mem [REG_CNT];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
        else if (we && waddr != '0)
            mem[waddr] <= wdata;

    // A write in flight wins over the stored value so readers see it this cycle
    assign rdata1 = raddr1 == '0 ? '0 : (we && waddr == raddr1) ? wdata : mem[raddr1];
    assign rdata2 = raddr2 == '0 ? '0 : (we && waddr == raddr2) ? wdata : mem[raddr2];
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decodes instructions into adder operands through one valid/ready slot
module operand_fetch_stage
    import operand_fetch_stage_pkg::SUB, operand_fetch_stage_pkg::ADC, operand_fetch_stage_pkg::INC;
#(
    parameter int DATA_W  = operand_fetch_stage_pkg::DATA_W,
    parameter int REG_CNT = operand_fetch_stage_pkg::REG_CNT
) (
    input logic                  clk,
    input logic                  rst_n,
    operand_fetch_stage_if.slave bus
);
    localparam int ADDR_W = $clog2(REG_CNT);

    logic [DATA_W-1:0] src1, src2, raw_b, dec_b, out_a, out_b;
    logic [ADDR_W-1:0] out_rd;
    logic              cf, cf_eff, dec_ci, in_ready, accept, out_valid, out_ci;

    reg_file_2r1w #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bus.wb_en),
        .waddr  (bus.wb_addr),
        .wdata  (bus.wb_data),
        .raddr1 (bus.in_rs1),
        .rdata1 (src1),
        .raddr2 (bus.in_rs2),
        .rdata2 (src2)
    );

    // SUB is a + ~b + 1; INC is a + 0 + 1
    always_comb begin
        cf_eff = bus.wb_carry_en ? bus.wb_carry : cf;
        raw_b  = bus.in_use_imm ? bus.in_imm : src2;
        dec_b  = bus.in_op == INC ? '0 : bus.in_op == SUB ? ~raw_b : raw_b;
        dec_ci = bus.in_op == SUB || bus.in_op == INC || (bus.in_op == ADC && cf_eff);
    end

    assign in_ready = !out_valid || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cf <= 1'b0;
        else if (bus.wb_carry_en)
            cf <= bus.wb_carry;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_ci    <= 1'b0;
            out_rd    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= src1;
            out_b     <= dec_b;
            out_ci    <= dec_ci;
            out_rd    <= bus.in_rd;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_a     = out_a;
    assign bus.out_b     = out_b;
    assign bus.out_ci    = out_ci;
    assign bus.out_rd    = out_rd;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed and random stimulus against an instruction-level model of the stage
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_stage_if bus ();
    operand_fetch_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] m_rf [8];
    logic       m_cf;
    logic       exp_v, exp_ci;
    logic [7:0] exp_a, exp_b, exp_res;
    logic [2:0] exp_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        foreach (m_rf[i]) m_rf[i] = 8'h00;
        m_cf = 1'b0;
        exp_v = 1'b0; exp_ci = 1'b0;
        exp_a = 8'h00; exp_b = 8'h00; exp_res = 8'h00; exp_rd = 3'd0;
    endtask

    function automatic logic [7:0] rd_model(input logic [2:0] a);
        return a == 3'd0 ? 8'h00 : (bus.wb_en && bus.wb_addr == a) ? bus.wb_data : m_rf[a];
    endfunction

    task automatic idle();
        bus.in_valid = 1'b0; bus.in_op = ADD; bus.in_rs1 = 3'd0; bus.in_rs2 = 3'd0;
        bus.in_use_imm = 1'b0; bus.in_imm = 8'h00; bus.in_rd = 3'd0; bus.out_ready = 1'b1;
        bus.wb_en = 1'b0; bus.wb_addr = 3'd0; bus.wb_data = 8'h00;
        bus.wb_carry_en = 1'b0; bus.wb_carry = 1'b0;
    endtask

    // Inputs are already applied; predict the slot and architectural state after the next edge
    task automatic do_cycle();
        logic [7:0] s1, rb;
        logic cfe;
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(!exp_v || bus.out_ready));
        s1  = rd_model(bus.in_rs1);
        rb  = bus.in_use_imm ? bus.in_imm : rd_model(bus.in_rs2);
        cfe = bus.wb_carry_en ? bus.wb_carry : m_cf;
        if (bus.in_valid && (!exp_v || bus.out_ready)) begin
            exp_v = 1'b1; exp_a = s1; exp_rd = bus.in_rd;
            case (bus.in_op)
                ADD: begin exp_b = rb; exp_ci = 1'b0; exp_res = s1 + rb; end
                SUB: begin exp_b = 8'hFF - rb; exp_ci = 1'b1; exp_res = s1 - rb; end
                ADC: begin exp_b = rb; exp_ci = cfe; exp_res = s1 + rb + 8'(cfe); end
                default: begin exp_b = 8'h00; exp_ci = 1'b1; exp_res = s1 + 8'd1; end
            endcase
        end else if (bus.out_ready) begin
            exp_v = 1'b0;
        end
        if (bus.wb_en && bus.wb_addr != 3'd0) m_rf[bus.wb_addr] = bus.wb_data;
        if (bus.wb_carry_en) m_cf = bus.wb_carry;
        @(posedge clk);
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(exp_v));
        if (exp_v) begin
            check("out_a", 32'(bus.out_a), 32'(exp_a));
            check("out_b", 32'(bus.out_b), 32'(exp_b));
            check("out_ci", 32'(bus.out_ci), 32'(exp_ci));
            check("out_rd", 32'(bus.out_rd), 32'(exp_rd));
            check("adder_sum", 32'(8'(bus.out_a + bus.out_b + 8'(bus.out_ci))), 32'(exp_res));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_a"}, 32'(bus.out_a), 32'd0);
        check({tag, "_b"}, 32'(bus.out_b), 32'd0);
        check({tag, "_ci"}, 32'(bus.out_ci), 32'd0);
        check({tag, "_rd"}, 32'(bus.out_rd), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        #1;
        check("rst_in_ready_during", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        idle(); bus.in_valid = 1'b1; bus.in_rs1 = 3'd1; bus.in_rs2 = 3'd2; do_cycle();
        check("rst_add_a", 32'(bus.out_a), 32'h00);
        check("rst_add_b", 32'(bus.out_b), 32'h00);
        check("rst_add_ci", 32'(bus.out_ci), 32'd0);

        idle(); bus.wb_en = 1'b1; bus.wb_addr = 3'd1; bus.wb_data = 8'h3C; do_cycle();
        idle(); bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 8'h05; do_cycle();
        idle(); bus.in_valid = 1'b1; bus.in_op = SUB; bus.in_rs1 = 3'd1; bus.in_rs2 = 3'd2; bus.in_rd = 3'd3; do_cycle();
        check("sub_a", 32'(bus.out_a), 32'h3C);
        check("sub_b", 32'(bus.out_b), 32'hFA);
        check("sub_ci", 32'(bus.out_ci), 32'd1);
        check("sub_rd", 32'(bus.out_rd), 32'd3);

        idle(); bus.wb_en = 1'b1; bus.wb_addr = 3'd4; bus.wb_data = 8'h7F;
        bus.in_valid = 1'b1; bus.in_rs1 = 3'd4; bus.in_use_imm = 1'b1; bus.in_imm = 8'h01; do_cycle();
        check("fwd_a", 32'(bus.out_a), 32'h7F);
        check("fwd_b", 32'(bus.out_b), 32'h01);

        idle(); bus.in_valid = 1'b1; bus.in_op = ADC; bus.wb_carry_en = 1'b1; bus.wb_carry = 1'b1; do_cycle();
        check("adc_fwd_ci", 32'(bus.out_ci), 32'd1);
        idle(); bus.in_valid = 1'b1; bus.in_op = ADC; do_cycle();
        check("adc_cf_ci", 32'(bus.out_ci), 32'd1);

        idle(); bus.in_valid = 1'b1; bus.in_rs1 = 3'd1; bus.in_rs2 = 3'd2; bus.in_rd = 3'd5; do_cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); bus.out_ready = 1'b0;
            bus.in_valid = 1'b1; bus.in_op = SUB; bus.in_rs1 = 3'd2; bus.in_rs2 = 3'd1; bus.in_rd = 3'd6;
            #1;
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            do_cycle();
            check("stall_hold_a", 32'(bus.out_a), 32'h3C);
            check("stall_hold_rd", 32'(bus.out_rd), 32'd5);
        end
        bus.out_ready = 1'b1; do_cycle();
        check("resume_a", 32'(bus.out_a), 32'h05);
        check("resume_b", 32'(bus.out_b), 32'hC3);
        check("resume_rd", 32'(bus.out_rd), 32'd6);
        idle(); do_cycle();
        check("no_dup_valid", 32'(bus.out_valid), 32'd0);

        idle(); bus.wb_en = 1'b1; bus.wb_addr = 3'd0; bus.wb_data = 8'hAA; do_cycle();
        idle(); bus.in_valid = 1'b1; bus.in_op = INC; bus.in_rs2 = 3'd2; bus.in_imm = 8'h55; do_cycle();
        check("r0_inc_a", 32'(bus.out_a), 32'h00);
        check("r0_inc_b", 32'(bus.out_b), 32'h00);
        check("r0_inc_ci", 32'(bus.out_ci), 32'd1);

        idle(); bus.in_valid = 1'b1; bus.in_rs1 = 3'd1; do_cycle();
        idle(); bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.wb_en = 1'b1; bus.wb_addr = 3'd5; bus.wb_data = 8'h11; do_cycle();
        async_reset();
        idle(); bus.in_valid = 1'b1; bus.in_rs1 = 3'd1; bus.in_rs2 = 3'd5; bus.in_rd = 3'd2; do_cycle();
        check("post_rst_a", 32'(bus.out_a), 32'h00);
        check("post_rst_b", 32'(bus.out_b), 32'h00);

        for (int i = 0; i < 600; i++) begin
            bus.in_valid    = 1'($urandom_range(0, 1));
            bus.in_op       = op_t'($urandom_range(0, 3));
            bus.in_rs1      = 3'($urandom);
            bus.in_rs2      = 3'($urandom);
            bus.in_use_imm  = 1'($urandom_range(0, 1));
            bus.in_imm      = 8'($urandom);
            bus.in_rd       = 3'($urandom);
            bus.out_ready   = $urandom_range(0, 9) < 7;
            bus.wb_en       = $urandom_range(0, 9) < 6;
            bus.wb_addr     = 3'($urandom);
            bus.wb_data     = 8'($urandom);
            bus.wb_carry_en = 1'($urandom_range(0, 1));
            bus.wb_carry    = 1'($urandom_range(0, 1));
            do_cycle();
            if (i == 300) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Upstream stage of the 8-bit ripple-carry adder in the 3-stage processor. Holds the 8×8-bit register file and carry flag. Decodes an issued instruction into adder operands `a`, `b` and `ci`, and registers them in a single valid/ready pipeline slot that feeds the adder. Applies writeback results and forwards them combinationally in the same cycle they are written.

## Interface
Parameters:
- `DATA_W`, 8, operand/register width; must match adder width.
- `REG_CNT`, 8, number of registers; `ADDR_W` = clog2(`REG_CNT`) = 3.

Ports:
- `clk` input 1, single clock; all state updates on the rising edge.
- `rst_n` input 1, asynchronous active-low reset.
- `in_valid` input 1, instruction offered.
- `in_ready` output 1, stage can accept this cycle.
- `in_op` input 2, `ADD`=0, `SUB`=1, `ADC`=2, `INC`=3.
- `in_rs1` input `ADDR_W`, source register for `a`.
- `in_rs2` input `ADDR_W`, source register for `b` (ignored when `in_use_imm`=1).
- `in_use_imm` input 1, select `in_imm` instead of `rs2`.
- `in_imm` input `DATA_W`, immediate operand.
- `in_rd` input `ADDR_W`, destination register, passed through.
- `out_valid` output 1, registered operands valid.
- `out_ready` input 1, downstream accepts.
- `out_a`, `out_b` output `DATA_W`, adder operands.
- `out_ci` output 1, adder carry-in.
- `out_rd` output `ADDR_W`, destination, aligned with operands.
- `wb_en` input 1, register write strobe.
- `wb_addr` input `ADDR_W`, write address.
- `wb_data` input `DATA_W`, write data.
- `wb_carry_en` input 1, carry-flag write strobe.
- `wb_carry` input 1, new carry flag (adder `co`).

## Operation
- Register file: `REG_CNT` × `DATA_W`. `r0` reads as 0 always; writes to `r0` are dropped. Registers `r1`..`r7` are written on the edge when `wb_en`=1.
- Carry flag `cf`: 1 bit, written on the edge when `wb_carry_en`=1.
- Read with forwarding:
  - `src1` = (`wb_en` && `wb_addr`==`in_rs1` && `in_rs1`≠0) ? `wb_data` : `rf[in_rs1]`. `src2` is formed the same way from `in_rs2`.
  - `cf_eff` = `wb_carry_en` ? `wb_carry` : `cf`.
- Raw `b` = `in_use_imm` ? `in_imm` : `src2`.
- Operand decode:
  - `ADD`: `a`=`src1`, `b`=raw b, `ci`=0.
  - `SUB`: `a`=`src1`, `b`=~raw b, `ci`=1 (two's complement).
  - `ADC`: `a`=`src1`, `b`=raw b, `ci`=`cf_eff`.
  - `INC`: `a`=`src1`, `b`=0, `ci`=1; `rs2` and immediate are ignored.
- Handshake:
  - `in_ready` = !`out_valid` || `out_ready`.
  - Accept = `in_valid` && `in_ready`.
  - On accept, load the `out_*` registers and set `out_valid`=1.
  - Else if `out_ready`, clear `out_valid`.
  - While `out_valid` && !`out_ready`, all `out_*` registers hold stable.
- Writeback is independent of the handshake: it is applied even while the stage is stalled. A stalled slot is not re-read; its operands stay as captured.

## Timing
- Latency: 1 cycle from accept to `out_valid`. Throughput: 1 per cycle when `out_ready`=1.
- Reset (async assert, sync release):
  - `out_valid`=0, `out_a`=0, `out_b`=0, `out_ci`=0, `out_rd`=0.
  - All registers = 0, `cf`=0.
  - `in_ready`=1 during and after reset.
- Simultaneous writeback and read of the same register: the new value is used (forwarded).
- Simultaneous `wb_carry_en` and `ADC`: the new carry is used.
- Simultaneous accept and `out_ready` (back-to-back): the slot is replaced and `out_valid` stays 1.
- Reset asserted mid-stall: the pending slot is discarded and writes are lost. No output glitch beyond the reset values.

## Structure
- A shared package holds the `op_t` enum (`ADD`/`SUB`/`ADC`/`INC`), `DATA_W`, and `REG_CNT`, used by this stage, the adder wrapper, and writeback.
- One sub-module: `reg_file_2r1w`, which provides two async read ports, one sync write port, `r0` hardwired to zero, and a per-port bypass. Decode and the pipeline slot stay in the top level.

## Test plan
- Reset: assert `rst_n`=0 mid-run → all outputs 0, `in_ready`=1; after release, `ADD` `r1`,`r2` → `out_a`=0, `out_b`=0, `out_ci`=0.
- Write `r1`=0x3C, `r2`=0x05, then `SUB` `rd`=3 → `out_a`=0x3C, `out_b`=0xFA, `out_ci`=1, `out_rd`=3 one cycle after accept.
- Forwarding: same cycle `wb_en` `r4`=0x7F and `ADD` `rs1`=4 with `in_use_imm`, `in_imm`=0x01 → `out_a`=0x7F, `out_b`=0x01.
- Carry: `wb_carry_en`=1 with `wb_carry`=1 in the same cycle as `ADC` `r0`,`r0` → `out_ci`=1; next `ADC` with no strobe → `out_ci`=1 (from stored `cf`).
- Stall: `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and `out_*` stable. `out_ready`=1 → the next instruction is captured the following cycle, with no loss or duplication.
- `r0`: write 0xAA to `r0`, then `INC` `rs1`=0 → `out_a`=0, `out_b`=0, `out_ci`=1.
